axi_lite_a32_d32_slave_regfile: RTL

//  AXI4-Lite (A32/D32) register-file endpoint that sits directly downstream of the
//  AXI-Lite slave-side logic-link adapter, on its user_* AXI-Lite master-facing signals.

---
 rtl/axi_lite_a32_d32_slave_regfile.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi_lite_a32_d32_slave_regfile.sv
// AXI4-Lite A32/D32 register-file endpoint: NUM_REGS x 32-bit registers,
// independent read and write FSMs, registered responses.
module axi_lite_a32_d32_slave_regfile #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_wr,
    input  logic        rst_wr_n,
    input  logic [31:0] user_araddr,
    input  logic        user_arvalid,
    output logic        user_arready,
    input  logic [31:0] user_awaddr,
    input  logic        user_awvalid,
    output logic        user_awready,
    input  logic [31:0] user_wdata,
    input  logic [3:0]  user_wstrb,
    input  logic        user_wvalid,
    output logic        user_wready,
    output logic [31:0] user_rdata,
    output logic [1:0]  user_rresp,
    output logic        user_rvalid,
    input  logic        user_rready,
    output logic [1:0]  user_bresp,
    output logic        user_bvalid,
    input  logic        user_bready
);
    localparam int unsigned IW   = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic        rdy_en_q;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        aw_cap_q, aw_cap_d;
    logic        w_cap_q, w_cap_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    // 33-bit subtract: bit 32 is the borrow, set when addr < BASE_ADDR
    logic [32:0] ar_diff, aw_diff;
    logic        ar_hit, aw_hit;
    logic [IW-1:0] ar_idx, aw_idx;

    assign ar_diff = {1'b0, user_araddr} - {1'b0, BASE_ADDR};
    assign aw_diff = {1'b0, awaddr_q} - {1'b0, BASE_ADDR};
    assign ar_hit  = !ar_diff[32] && (ar_diff[31:0] < SPAN);
    assign aw_hit  = !aw_diff[32] && (aw_diff[31:0] < SPAN);
    assign ar_idx  = ar_diff[2 +: IW];
    assign aw_idx  = aw_diff[2 +: IW];

    // rdy_en_q holds all readies low during and on the edge of reset
    assign user_arready = rdy_en_q && (r_state_q == R_IDLE);
    assign user_awready = rdy_en_q && (w_state_q == W_IDLE) && !aw_cap_q;
    assign user_wready  = rdy_en_q && (w_state_q == W_IDLE) && !w_cap_q;
    assign user_rvalid  = (r_state_q == R_RESP);
    assign user_bvalid  = (w_state_q == W_RESP);
    assign user_rdata   = rdata_q;
    assign user_rresp   = rresp_q;
    assign user_bresp   = bresp_q;

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (user_arvalid && user_arready) begin
                    r_state_d = R_RESP;
                    rdata_d   = ar_hit ? regs_q[ar_idx] : 32'h0;
                    rresp_d   = ar_hit ? OKAY : SLVERR;
                end
            end
            R_RESP: begin
                if (user_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_cap_d  = aw_cap_q;
        w_cap_d   = w_cap_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (user_awvalid && user_awready) begin
                    aw_cap_d = 1'b1;
                    awaddr_d = user_awaddr;
                end
                if (user_wvalid && user_wready) begin
                    w_cap_d = 1'b1;
                    wdata_d = user_wdata;
                    wstrb_d = user_wstrb;
                end
                if (aw_cap_d && w_cap_d) w_state_d = W_COMMIT;
            end
            W_COMMIT: begin
                if (aw_hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b]) regs_d[aw_idx][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
                bresp_d   = aw_hit ? OKAY : SLVERR;
                aw_cap_d  = 1'b0;
                w_cap_d   = 1'b0;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (user_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            rdy_en_q  <= 1'b0;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= '0;
            w_state_q <= W_IDLE;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            rdy_en_q  <= 1'b1;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            regs_q    <= regs_d;
        end
    end
endmodule
